// File: rtl/fpro_bridge_pkg.sv
// Shared constants and state encoding for the byte-stream to FPro MMIO bridge.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package fpro_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_TO  = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_STROBE,
        ST_RESP
    } state_t;

    // Places a single response byte in the MSB lane so the serializer emits it first.
    function automatic logic [31:0] rsp_word(input logic [7:0] b);
        return {b, 24'h000000};
    endfunction

endpackage

// File: rtl/bridge_tx_serializer.sv
// Emits a loaded 32-bit word (1 or 4 bytes, MSB first) on a valid/ready byte stream.
// Latency: tx_valid rises the cycle after load; done pulses with the last handshake.
// Backpressure: tx_valid/tx_data hold while tx_ready is low; load is ignored-safe only when idle.
module bridge_tx_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [2:0]  load_len,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] shreg;
    logic [2:0]  remain;
    logic        xfer;

    assign xfer    = tx_valid && tx_ready;
    assign tx_data = shreg[31:24];
    assign done    = xfer && (remain == 3'd1);

    // Shift register advances one byte per accepted handshake; valid drops after the last.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            remain   <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shreg    <= load_word;
            remain   <= load_len;
            tx_valid <= (load_len != 3'd0);
        end else if (xfer) begin
            shreg  <= {shreg[23:0], 8'h00};
            remain <= remain - 3'd1;
            if (remain == 3'd1) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fpro_mmio_master_bridge.sv
// Parses 'W'/'R' byte commands into single-cycle FPro MMIO accesses and streams back ack/read data.
// Latency: last cmd byte at edge k -> REQ cycle k+1, STROBE k+2, first tx byte k+3 (gnt and tx_ready high).
// Backpressure: rx_ready low outside IDLE/ADDR/DATA; waits indefinitely on bus_gnt; tx held until tx_ready.
module fpro_mmio_master_bridge
    import fpro_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        mmio_cs,
    output logic        mmio_wr,
    output logic        mmio_rd,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        busy
);

    // A disabled timeout still needs a legal one-bit counter.
    localparam int unsigned CW = (TO_W < 1) ? 1 : TO_W;

    state_t        state;
    logic          op_wr;
    logic [1:0]    byte_cnt;
    logic [CW-1:0] to_cnt;
    logic [20:0]   addr_q;
    logic [31:0]   wdata_q;

    logic          rx_xfer;
    logic          is_cmd;
    logic          to_hit;
    logic          ser_load;
    logic [31:0]   ser_word;
    logic [2:0]    ser_len;
    logic          ser_done;

    assign rx_ready = (state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA);
    assign rx_xfer  = rx_valid && rx_ready;
    assign is_cmd   = (rx_data == CMD_WR) || (rx_data == CMD_RD);
    // Fires on the idle cycle that would bring the counter up to TIMEOUT_CYC.
    assign to_hit   = (TIMEOUT_CYC != 0) && ((32'(to_cnt) + 32'd1) == TIMEOUT_CYC);

    assign bus_req      = (state == ST_REQ) || (state == ST_STROBE);
    assign mmio_cs      = (state == ST_STROBE);
    assign mmio_wr      = mmio_cs && op_wr;
    assign mmio_rd      = mmio_cs && !op_wr;
    assign mmio_addr    = addr_q;
    assign mmio_wr_data = wdata_q;
    assign busy         = (state != ST_IDLE);

    // Select the response word on every transition into RESP.
    always_comb begin
        ser_load = 1'b0;
        ser_word = '0;
        ser_len  = 3'd1;
        case (state)
            ST_IDLE: begin
                if (rx_xfer && !is_cmd) begin
                    ser_load = 1'b1;
                    ser_word = rsp_word(RSP_BAD);
                end
            end
            ST_ADDR, ST_DATA: begin
                if (!rx_xfer && to_hit) begin
                    ser_load = 1'b1;
                    ser_word = rsp_word(RSP_TO);
                end
            end
            ST_STROBE: begin
                ser_load = 1'b1;
                if (op_wr) begin
                    ser_word = rsp_word(RSP_ACK);
                end else begin
                    ser_word = mmio_rd_data;
                    ser_len  = 3'd4;
                end
            end
            default: begin
            end
        endcase
    end

    // Command parser, inter-byte timeout and bus sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_wr    <= 1'b0;
            byte_cnt <= '0;
            to_cnt   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_xfer) begin
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                        if (is_cmd) begin
                            op_wr <= (rx_data == CMD_WR);
                            state <= ST_ADDR;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_xfer) begin
                        to_cnt   <= '0;
                        addr_q   <= {addr_q[12:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2) begin
                            byte_cnt <= '0;
                            state    <= op_wr ? ST_DATA : ST_REQ;
                        end
                    end else if (to_hit) begin
                        to_cnt <= '0;
                        state  <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_xfer) begin
                        to_cnt   <= '0;
                        wdata_q  <= {wdata_q[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= '0;
                            state    <= ST_REQ;
                        end
                    end else if (to_hit) begin
                        to_cnt <= '0;
                        state  <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (ser_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    bridge_tx_serializer u_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_word (ser_word),
        .load_len  (ser_len),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_fpro_mmio_master_bridge.sv
// Randomized command stream against a command-level model of the bridge.
// Latency: n/a (testbench).
// Backpressure: drives random tx_ready and bus_gnt stalls.
module tb_fpro_mmio_master_bridge;

    localparam int unsigned TO = 20;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic [7:0]  rx_data      = 8'h00;
    logic        rx_valid     = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready     = 1'b1;
    logic        bus_req;
    logic        bus_gnt      = 1'b1;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data = 32'h0;
    logic        busy;

    fpro_mmio_master_bridge #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .bus_req      (bus_req),
        .bus_gnt      (bus_gnt),
        .mmio_cs      (mmio_cs),
        .mmio_wr      (mmio_wr),
        .mmio_rd      (mmio_rd),
        .mmio_addr    (mmio_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (mmio_rd_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // cyc == e during the clock period that follows rising edge e.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [20:0] addr;
        logic [31:0] wdata;
        int          at;
    } strobe_t;

    strobe_t    sq[$];
    logic [7:0] txq[$];
    int         txv_rise[$];
    int         req_total = 0;
    logic       prev_txv  = 1'b0;

    // Record strobes, tx handshakes, tx_valid rises and bus_req cycles mid-cycle.
    always @(negedge clk) begin
        strobe_t s;
        if (!reset) begin
            if (mmio_cs) begin
                s.wr    = mmio_wr;
                s.rd    = mmio_rd;
                s.addr  = mmio_addr;
                s.wdata = mmio_wr_data;
                s.at    = cyc;
                sq.push_back(s);
            end
            if (bus_req) req_total++;
            if (tx_valid && !prev_txv) txv_rise.push_back(cyc);
            if (tx_valid && tx_ready) txq.push_back(tx_data);
        end
        prev_txv = tx_valid;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Command under test and the model's expectation for it.
    logic [7:0]  cmd[8];
    int          cmd_n;
    logic        exp_strobe;
    logic        exp_wr;
    logic [20:0] exp_addr;
    logic [31:0] exp_wd;
    logic [7:0]  exp_rsp[$];

    task automatic set_cmd(input logic [63:0] bytes, input int n);
        for (int i = 0; i < 8; i++) cmd[i] = bytes[63 - 8*i -: 8];
        cmd_n = n;
    endtask

    // kind 0 = write, 1 = read, 2 = unknown opcode
    task automatic rand_cmd(input int kind);
        for (int i = 0; i < 8; i++) cmd[i] = 8'($urandom);
        if (kind == 0) begin
            cmd[0] = 8'h57; cmd_n = 8;
        end else if (kind == 1) begin
            cmd[0] = 8'h52; cmd_n = 4;
        end else begin
            while (cmd[0] == 8'h57 || cmd[0] == 8'h52) cmd[0] = 8'($urandom);
            cmd_n = 1;
        end
    endtask

    // Command-level expectation from the bytes actually sent.
    task automatic model(input int nsent, input logic [31:0] rdw);
        longint b[8];
        longint w;
        longint d;
        for (int i = 0; i < 8; i++) b[i] = longint'(cmd[i]);
        exp_rsp.delete();
        exp_strobe = 1'b0;
        exp_wr     = 1'b0;
        exp_addr   = '0;
        exp_wd     = '0;
        if (b[0] != 'h57 && b[0] != 'h52) begin
            exp_rsp.push_back(8'h3F);
        end else if ((b[0] == 'h57 && nsent < 8) || (b[0] == 'h52 && nsent < 4)) begin
            exp_rsp.push_back(8'h54);
        end else begin
            exp_strobe = 1'b1;
            exp_wr     = (b[0] == 'h57);
            exp_addr   = 21'((b[1] % 32) * 65536 + b[2] * 256 + b[3]);
            exp_wd     = 32'(b[4] * 16777216 + b[5] * 65536 + b[6] * 256 + b[7]);
            if (exp_wr) begin
                exp_rsp.push_back(8'h4B);
            end else begin
                w = longint'(rdw);
                d = 16777216;
                for (int i = 0; i < 4; i++) begin
                    exp_rsp.push_back(8'((w / d) % 256));
                    d = d / 256;
                end
            end
        end
    endtask

    // Present one byte after 'gap' idle cycles; 'at' is the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input int gap, output int at);
        int n;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        rx_data  = b;
        rx_valid = 1'b1;
        at = -1;
        n  = 0;
        while (at < 0 && n < 100) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                at = cyc;
            end
            n++;
        end
        rx_valid = 1'b0;
        check("rx_accepted", (at >= 0), 1);
    endtask

    task automatic wait_resp(input int nexp, input int tx0, input logic rnd_ready);
        int n;
        n = 0;
        while ((txq.size() - tx0) < nexp && n < 400) begin
            @(posedge clk);
            #1;
            if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        tx_ready = 1'b1;
    endtask

    task automatic run_txn(input string name, input int nsend, input int gnt_wait,
                           input logic rnd_ready, input int late_gap, input logic [31:0] rdw);
        int n, k, g, bad, gap, sq0, tx0, rise0, req0, ftx;
        @(posedge clk);
        #1;
        n = (nsend == 0) ? cmd_n : nsend;
        mmio_rd_data = rdw;
        model(n, rdw);
        sq0   = sq.size();
        tx0   = txq.size();
        rise0 = txv_rise.size();
        req0  = req_total;
        bus_gnt  = (gnt_wait == 0);
        tx_ready = 1'b1;
        k = 0;
        for (int i = 0; i < n; i++) begin
            gap = (late_gap > 0 && i == 2) ? late_gap : int'($urandom_range(0, 2));
            send_byte(cmd[i], gap, k);
        end
        g = k;
        if (gnt_wait > 0) begin
            bad = 0;
            for (int i = 0; i < gnt_wait; i++) begin
                @(negedge clk);
                if (bus_req !== 1'b1 || mmio_cs !== 1'b0) bad++;
            end
            check({name, "/gnt_stall"}, bad, 0);
            @(posedge clk);
            #1;
            g = cyc;
            bus_gnt = 1'b1;
        end
        wait_resp(exp_rsp.size(), tx0, rnd_ready);
        @(negedge clk);
        check({name, "/busy_after"}, busy, 0);
        check({name, "/rx_ready_after"}, rx_ready, 1);
        check({name, "/tx_valid_after"}, tx_valid, 0);
        check({name, "/n_strobe"}, sq.size() - sq0, exp_strobe);
        ftx = (txv_rise.size() > rise0) ? txv_rise[rise0] : -1;
        if (exp_strobe && sq.size() - sq0 == 1) begin
            check({name, "/wr"}, sq[sq0].wr, exp_wr);
            check({name, "/rd"}, sq[sq0].rd, !exp_wr);
            check({name, "/addr"}, sq[sq0].addr, exp_addr);
            if (exp_wr) check({name, "/wdata"}, sq[sq0].wdata, exp_wd);
            check({name, "/strobe_cycle"}, sq[sq0].at, g + 1);
            check({name, "/first_tx_cycle"}, ftx, g + 2);
            check({name, "/req_cycles"}, req_total - req0, g - k + 2);
        end else if (!exp_strobe) begin
            check({name, "/req_cycles"}, req_total - req0, 0);
            if (exp_rsp[0] == 8'h54) check({name, "/timeout_cycle"}, ftx, k + int'(TO));
        end
        check({name, "/n_resp"}, txq.size() - tx0, exp_rsp.size());
        for (int i = 0; i < exp_rsp.size(); i++) begin
            if (tx0 + i < txq.size()) check({name, "/resp_byte"}, txq[tx0 + i], exp_rsp[i]);
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, "/rx_ready"}, rx_ready, 1);
        check({tag, "/tx_valid"}, tx_valid, 0);
        check({tag, "/tx_data"}, tx_data, 0);
        check({tag, "/bus_req"}, bus_req, 0);
        check({tag, "/cs_wr_rd"}, {mmio_cs, mmio_wr, mmio_rd}, 0);
        check({tag, "/addr"}, mmio_addr, 0);
        check({tag, "/wr_data"}, mmio_wr_data, 0);
        check({tag, "/busy"}, busy, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind, ns, gw, k, bad, n, tx0;
        logic rr;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rst("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        set_cmd(64'h57_00_02_04_DE_AD_BE_EF, 8);
        run_txn("dir_wr", 0, 0, 1'b0, 0, 32'h0);

        set_cmd(64'h52_E0_00_21_00_00_00_00, 4);
        run_txn("dir_rd", 0, 0, 1'b0, 0, 32'h12345678);

        rand_cmd(1);
        run_txn("gnt_stall_rd", 0, 50, 1'b0, 0, $urandom);

        set_cmd(64'h41_00_00_00_00_00_00_00, 1);
        run_txn("bad_cmd", 0, 0, 1'b0, 0, 32'h0);
        rand_cmd(1);
        run_txn("after_bad", 0, 0, 1'b0, 0, $urandom);

        set_cmd(64'h57_00_00_00_00_00_00_00, 8);
        run_txn("timeout", 2, 0, 1'b0, 0, 32'h0);
        rand_cmd(0);
        run_txn("after_to", 0, 0, 1'b0, 0, 32'h0);

        // Byte arrives on the very cycle the timeout would expire.
        rand_cmd(0);
        run_txn("to_edge", 0, 0, 1'b0, int'(TO) - 1, 32'h0);

        // Read response stalled by tx_ready, then reset mid-response.
        @(posedge clk);
        #1;
        set_cmd(64'h52_E0_00_21_00_00_00_00, 4);
        mmio_rd_data = 32'h12345678;
        bus_gnt  = 1'b1;
        tx_ready = 1'b0;
        tx0 = txq.size();
        for (int i = 0; i < 4; i++) send_byte(cmd[i], 0, k);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 20);
        check("bp/valid_seen", tx_valid, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h12) bad++;
        end
        check("bp/hold", bad, 0);
        check("bp/none_sent", txq.size() - tx0, 0);
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        reset    = 1'b1;
        check("bp/first_byte_count", txq.size() - tx0, 1);
        if (txq.size() > tx0) check("bp/first_byte", txq[tx0], 8'h12);
        @(posedge clk);
        @(negedge clk);
        check_rst("mid_reset");
        @(posedge clk);
        #1;
        reset    = 1'b0;
        tx_ready = 1'b1;
        rand_cmd(0);
        run_txn("after_reset", 0, 0, 1'b0, 0, 32'h0);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4)       rand_cmd(0);
            else if (kind < 8)  rand_cmd(1);
            else if (kind == 8) rand_cmd(2);
            else                rand_cmd($urandom_range(0, 1));
            ns = (kind == 9) ? int'($urandom_range(1, cmd_n - 1)) : 0;
            gw = (kind < 8 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            rr = 1'($urandom_range(0, 1));
            run_txn("rand", ns, gw, rr, 0, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
